// File: rtl/dcpu16_int_ctrl.sv
// DCPU-16 interrupt queue and delivery scheduler: SW/HW arbitration, FIFO, IA/IAQ/RFI rules.
// Optional overflow latch ("on fire") is enabled by defining DCPU16_INT_FIRE_EN.
module dcpu16_int_ctrl #(
    parameter int QUEUE_DEPTH = 256,
    parameter int NUM_SRC     = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    sw_int_valid,
    input  logic [15:0]             sw_int_msg,
    input  logic [NUM_SRC-1:0]      hw_int_req,
    input  logic [16*NUM_SRC-1:0]   hw_int_msg,
    output logic [NUM_SRC-1:0]      hw_int_ack,
    input  logic [15:0]             ia,
    input  logic                    iaq_wr,
    input  logic                    iaq_val,
    input  logic                    rfi,
    input  logic                    cpu_boundary,
    output logic                    int_take,
    output logic [15:0]             int_msg,
    output logic                    queueing,
    output logic [8:0]              queue_count,
    output logic                    on_fire
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);

    logic [15:0]        mem_r [QUEUE_DEPTH];
    logic [PTR_W-1:0]   head_r;
    logic [PTR_W-1:0]   tail_r;
    logic [8:0]         count_r;
    logic [4:0]         rr_ptr_r;
    logic               queueing_r;
    logic               on_fire_s;

    logic [4:0]         cand_s;
    logic [NUM_SRC-1:0] shifted_s;
    logic               hw_found_s;
    logic [4:0]         hw_idx_s;
    logic [4:0]         rr_next_s;
    logic               hw_accept_s;
    logic               arrival_s;
    logic [15:0]        arrival_msg_s;
    logic               full_s;
    logic               ia_on_s;
    logic               pop_s;
    logic               take_s;
    logic               push_s;

    // Round-robin search: first requesting source at or after rr_ptr_r.
    always_comb begin
        hw_found_s = 1'b0;
        hw_idx_s   = 5'd0;
        cand_s     = 5'd0;
        shifted_s  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cand_s = rr_ptr_r + 5'(i);
            if (cand_s >= 5'(NUM_SRC)) begin
                cand_s = cand_s - 5'(NUM_SRC);
            end else begin
                cand_s = cand_s;
            end
            shifted_s = hw_int_req >> cand_s;
            if (!hw_found_s && shifted_s[0]) begin
                hw_found_s = 1'b1;
                hw_idx_s   = cand_s;
            end else begin
                hw_found_s = hw_found_s;
            end
        end
    end

    // Pointer advances to the source after the one just acked.
    always_comb begin
        if (hw_idx_s == 5'(NUM_SRC - 1)) begin
            rr_next_s = 5'd0;
        end else begin
            rr_next_s = hw_idx_s + 5'd1;
        end
    end

    // Software INT wins outright; hardware only when the CPU is not executing INT.
    always_comb begin
        hw_accept_s = reset_n && !sw_int_valid && hw_found_s;
        arrival_s   = reset_n && (sw_int_valid || hw_found_s);
        if (sw_int_valid) begin
            arrival_msg_s = sw_int_msg;
        end else begin
            arrival_msg_s = 16'(hw_int_msg >> {hw_idx_s, 4'b0000});
        end
    end

    assign hw_int_ack = hw_accept_s ? (NUM_SRC'(1'b1) << hw_idx_s) : '0;

    // Queue control: a pop frees the slot a same-cycle push needs when full.
    always_comb begin
        full_s  = (count_r == 9'(QUEUE_DEPTH));
        ia_on_s = (ia != 16'h0000);
        pop_s   = (count_r != 9'd0) && !queueing_r && cpu_boundary && !on_fire_s;
        take_s  = pop_s && ia_on_s;
        push_s  = arrival_s && ia_on_s && (!full_s || pop_s);
    end

    assign int_take    = take_s;
    assign int_msg     = take_s ? mem_r[head_r] : 16'h0000;
    assign queueing    = queueing_r;
    assign queue_count = count_r;

    // Message storage; contents need no reset because count_r gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[tail_r] <= arrival_msg_s;
        end
    end

    // Pointers, occupancy, arbitration pointer and queueing flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_r     <= '0;
            tail_r     <= '0;
            count_r    <= 9'd0;
            rr_ptr_r   <= 5'd0;
            queueing_r <= 1'b0;
        end else begin
            if (push_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end
            if (pop_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 9'd1;
                2'b01:   count_r <= count_r - 9'd1;
                default: count_r <= count_r;
            endcase
            if (hw_accept_s) begin
                rr_ptr_r <= rr_next_s;
            end
            if (take_s) begin
                queueing_r <= 1'b1;
            end else if (iaq_wr) begin
                queueing_r <= iaq_val;
            end else if (rfi) begin
                queueing_r <= 1'b0;
            end else begin
                queueing_r <= queueing_r;
            end
        end
    end

`ifdef DCPU16_INT_FIRE_EN
    logic on_fire_r;

    // Overflow latches until reset and freezes delivery.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            on_fire_r <= 1'b0;
        end else if (arrival_s && ia_on_s && full_s && !pop_s) begin
            on_fire_r <= 1'b1;
        end else begin
            on_fire_r <= on_fire_r;
        end
    end

    assign on_fire_s = on_fire_r;
`else
    assign on_fire_s = 1'b0;
`endif

    assign on_fire = on_fire_s;

endmodule

// File: tb/tb_dcpu16_int_ctrl.sv
// Self-checking bench for dcpu16_int_ctrl: vector table plus fill/overflow/reset sequences.
module tb_dcpu16_int_ctrl;

`ifdef DCPU16_INT_FIRE_EN
    localparam bit FIRE = 1'b1;
`else
    localparam bit FIRE = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        sw_int_valid;
    logic [15:0] sw_int_msg;
    logic [3:0]  hw_int_req;
    logic [63:0] hw_int_msg;
    logic [3:0]  hw_int_ack;
    logic [15:0] ia;
    logic        iaq_wr;
    logic        iaq_val;
    logic        rfi;
    logic        cpu_boundary;
    logic        int_take;
    logic [15:0] int_msg;
    logic        queueing;
    logic [8:0]  queue_count;
    logic        on_fire;

    int checks   = 0;
    int failures = 0;

    dcpu16_int_ctrl #(.QUEUE_DEPTH(256), .NUM_SRC(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .sw_int_valid(sw_int_valid), .sw_int_msg(sw_int_msg),
        .hw_int_req(hw_int_req), .hw_int_msg(hw_int_msg), .hw_int_ack(hw_int_ack),
        .ia(ia), .iaq_wr(iaq_wr), .iaq_val(iaq_val), .rfi(rfi),
        .cpu_boundary(cpu_boundary),
        .int_take(int_take), .int_msg(int_msg), .queueing(queueing),
        .queue_count(queue_count), .on_fire(on_fire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sw_v;
        logic [15:0] sw_msg;
        logic [3:0]  req;
        logic [15:0] ia;
        logic        iaq_wr;
        logic        iaq_val;
        logic        rfi;
        logic        bnd;
        logic [3:0]  e_ack;
        logic        e_take;
        logic [15:0] e_msg;
        logic [8:0]  e_cnt;
        logic        e_q;
    } vec_t;

    vec_t vt[27];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        sw_int_valid = 1'b0;
        sw_int_msg   = 16'h0000;
        hw_int_req   = 4'h0;
        iaq_wr       = 1'b0;
        iaq_val      = 1'b0;
        rfi          = 1'b0;
        cpu_boundary = 1'b0;
    endtask

    function automatic vec_t mk(input logic sw_v, input logic [15:0] sw_msg, input logic [3:0] req,
                                input logic [15:0] ia_v, input logic iw, input logic iv,
                                input logic rf, input logic bnd, input logic [3:0] e_ack,
                                input logic e_take, input logic [15:0] e_msg,
                                input logic [8:0] e_cnt, input logic e_q);
        vec_t v;
        v.sw_v = sw_v; v.sw_msg = sw_msg; v.req = req; v.ia = ia_v;
        v.iaq_wr = iw; v.iaq_val = iv; v.rfi = rf; v.bnd = bnd;
        v.e_ack = e_ack; v.e_take = e_take; v.e_msg = e_msg; v.e_cnt = e_cnt; v.e_q = e_q;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        idle();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        hw_int_msg = {16'h0013, 16'h0012, 16'h0011, 16'h0010};
        ia = 16'h0100;
        idle();
        reset_n = 1'b0;
        hw_int_req = 4'hF;
        sw_int_valid = 1'b1;

        //            sw  msg       req   ia       iw  iv  rfi bnd   ack   take msg      cnt  q
        vt[0]  = mk(1'b1,16'h0042,4'h0,16'h0100,1'b0,1'b0,1'b0,1'b1, 4'h0,1'b0,16'h0000,9'd0,1'b0);
        vt[1]  = mk(1'b0,16'h0000,4'h0,16'h0100,1'b0,1'b0,1'b0,1'b1, 4'h0,1'b1,16'h0042,9'd1,1'b0);
        vt[2]  = mk(1'b0,16'h0000,4'h0,16'h0100,1'b0,1'b0,1'b0,1'b1, 4'h0,1'b0,16'h0000,9'd0,1'b1);
        vt[3]  = mk(1'b0,16'h0000,4'hF,16'h0100,1'b0,1'b0,1'b0,1'b1, 4'h1,1'b0,16'h0000,9'd0,1'b1);
        vt[4]  = mk(1'b0,16'h0000,4'hE,16'h0100,1'b0,1'b0,1'b0,1'b1, 4'h2,1'b0,16'h0000,9'd1,1'b1);
        vt[5]  = mk(1'b0,16'h0000,4'hC,16'h0100,1'b0,1'b0,1'b0,1'b1, 4'h4,1'b0,16'h0000,9'd2,1'b1);
        vt[6]  = mk(1'b0,16'h0000,4'h8,16'h0100,1'b0,1'b0,1'b0,1'b1, 4'h8,1'b0,16'h0000,9'd3,1'b1);
        vt[7]  = mk(1'b0,16'h0000,4'h0,16'h0100,1'b0,1'b0,1'b0,1'b1, 4'h0,1'b0,16'h0000,9'd4,1'b1);
        vt[8]  = mk(1'b0,16'h0000,4'h0,16'h0100,1'b0,1'b0,1'b1,1'b0, 4'h0,1'b0,16'h0000,9'd4,1'b1);
        vt[9]  = mk(1'b0,16'h0000,4'h0,16'h0100,1'b0,1'b0,1'b0,1'b1, 4'h0,1'b1,16'h0010,9'd4,1'b0);
        vt[10] = mk(1'b0,16'h0000,4'h0,16'h0100,1'b0,1'b0,1'b0,1'b1, 4'h0,1'b0,16'h0000,9'd3,1'b1);
        vt[11] = mk(1'b1,16'h0077,4'h4,16'h0100,1'b0,1'b0,1'b0,1'b1, 4'h0,1'b0,16'h0000,9'd3,1'b1);
        vt[12] = mk(1'b0,16'h0000,4'h4,16'h0100,1'b0,1'b0,1'b0,1'b1, 4'h4,1'b0,16'h0000,9'd4,1'b1);
        vt[13] = mk(1'b0,16'h0000,4'h0,16'h0100,1'b0,1'b0,1'b0,1'b1, 4'h0,1'b0,16'h0000,9'd5,1'b1);
        vt[14] = mk(1'b0,16'h0000,4'h0,16'h0100,1'b0,1'b0,1'b1,1'b0, 4'h0,1'b0,16'h0000,9'd5,1'b1);
        vt[15] = mk(1'b0,16'h0000,4'h0,16'h0100,1'b0,1'b0,1'b0,1'b1, 4'h0,1'b1,16'h0011,9'd5,1'b0);
        vt[16] = mk(1'b0,16'h0000,4'h0,16'h0100,1'b1,1'b0,1'b0,1'b0, 4'h0,1'b0,16'h0000,9'd4,1'b1);
        vt[17] = mk(1'b0,16'h0000,4'h0,16'h0100,1'b0,1'b0,1'b0,1'b1, 4'h0,1'b1,16'h0012,9'd4,1'b0);
        vt[18] = mk(1'b0,16'h0000,4'h2,16'h0000,1'b0,1'b0,1'b0,1'b1, 4'h2,1'b0,16'h0000,9'd3,1'b1);
        vt[19] = mk(1'b0,16'h0000,4'h0,16'h0000,1'b1,1'b0,1'b0,1'b0, 4'h0,1'b0,16'h0000,9'd3,1'b1);
        vt[20] = mk(1'b0,16'h0000,4'h0,16'h0000,1'b0,1'b0,1'b0,1'b1, 4'h0,1'b0,16'h0000,9'd3,1'b0);
        vt[21] = mk(1'b0,16'h0000,4'h0,16'h0000,1'b0,1'b0,1'b0,1'b1, 4'h0,1'b0,16'h0000,9'd2,1'b0);
        vt[22] = mk(1'b0,16'h0000,4'h0,16'h0000,1'b0,1'b0,1'b0,1'b1, 4'h0,1'b0,16'h0000,9'd1,1'b0);
        vt[23] = mk(1'b0,16'h0000,4'h0,16'h0000,1'b0,1'b0,1'b0,1'b1, 4'h0,1'b0,16'h0000,9'd0,1'b0);
        vt[24] = mk(1'b1,16'h0055,4'h0,16'h0100,1'b0,1'b0,1'b0,1'b1, 4'h0,1'b0,16'h0000,9'd0,1'b0);
        vt[25] = mk(1'b0,16'h0000,4'h0,16'h0100,1'b0,1'b0,1'b0,1'b1, 4'h0,1'b1,16'h0055,9'd1,1'b0);
        vt[26] = mk(1'b0,16'h0000,4'h0,16'h0100,1'b1,1'b1,1'b0,1'b0, 4'h0,1'b0,16'h0000,9'd0,1'b1);

        // Reset state, with requests pending to show acks stay quiet.
        @(negedge clk);
        @(negedge clk);
        #2;
        check("rst_ack", hw_int_ack, 4'h0);
        check("rst_take", int_take, 1'b0);
        check("rst_msg", int_msg, 16'h0000);
        check("rst_count", queue_count, 9'd0);
        check("rst_queueing", queueing, 1'b0);
        check("rst_on_fire", on_fire, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        idle();

        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            sw_int_valid = vt[i].sw_v;
            sw_int_msg   = vt[i].sw_msg;
            hw_int_req   = vt[i].req;
            ia           = vt[i].ia;
            iaq_wr       = vt[i].iaq_wr;
            iaq_val      = vt[i].iaq_val;
            rfi          = vt[i].rfi;
            cpu_boundary = vt[i].bnd;
            #2;
            check($sformatf("vec%0d_ack", i), hw_int_ack, vt[i].e_ack);
            check($sformatf("vec%0d_take", i), int_take, vt[i].e_take);
            if (vt[i].e_take) begin
                check($sformatf("vec%0d_msg", i), int_msg, vt[i].e_msg);
            end
            check($sformatf("vec%0d_count", i), queue_count, vt[i].e_cnt);
            check($sformatf("vec%0d_queueing", i), queueing, vt[i].e_q);
        end

        // Overflow: 257 software INTs into a 256-entry queue with no boundary.
        do_reset();
        ia = 16'h0100;
        for (int i = 0; i < 257; i++) begin
            @(negedge clk);
            idle();
            sw_int_valid = 1'b1;
            sw_int_msg   = 16'h1000 + 16'(i);
        end
        @(negedge clk);
        idle();
        #2;
        check("ovf_count", queue_count, 9'd256);
        check("ovf_on_fire", on_fire, FIRE);
        @(negedge clk);
        iaq_wr = 1'b1;
        iaq_val = 1'b0;
        @(negedge clk);
        idle();
        cpu_boundary = 1'b1;
        #2;
        check("ovf_queueing", queueing, 1'b0);
        check("ovf_take", int_take, !FIRE);
        if (!FIRE) begin
            check("ovf_msg", int_msg, 16'h1000);
        end
        @(negedge clk);
        idle();
        hw_int_req = 4'hF;
        sw_int_valid = 1'b1;
        cpu_boundary = 1'b1;
        reset_n = 1'b0;
        #2;
        check("midrst_ack", hw_int_ack, 4'h0);
        check("midrst_take", int_take, 1'b0);
        check("midrst_msg", int_msg, 16'h0000);
        check("midrst_count", queue_count, 9'd0);
        check("midrst_queueing", queueing, 1'b0);
        check("midrst_on_fire", on_fire, 1'b0);

        // Full queue with simultaneous push and pop, then drain in order.
        do_reset();
        ia = 16'h0100;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            idle();
            sw_int_valid = 1'b1;
            sw_int_msg   = 16'h2000 + 16'(i);
        end
        @(negedge clk);
        idle();
        #2;
        check("full_count", queue_count, 9'd256);
        check("full_queueing", queueing, 1'b0);
        @(negedge clk);
        sw_int_valid = 1'b1;
        sw_int_msg   = 16'hBEEF;
        cpu_boundary = 1'b1;
        #2;
        check("pp_take", int_take, 1'b1);
        check("pp_msg", int_msg, 16'h2000);
        @(negedge clk);
        idle();
        #2;
        check("pp_count", queue_count, 9'd256);
        check("pp_on_fire", on_fire, 1'b0);
        check("pp_queueing", queueing, 1'b1);
        for (int k = 1; k <= 256; k++) begin
            @(negedge clk);
            idle();
            rfi = 1'b1;
            @(negedge clk);
            idle();
            cpu_boundary = 1'b1;
            #2;
            check($sformatf("drain%0d_take", k), int_take, 1'b1);
            check($sformatf("drain%0d_msg", k), int_msg, (k < 256) ? (16'h2000 + 16'(k)) : 16'hBEEF);
        end
        @(negedge clk);
        idle();
        #2;
        check("drain_count", queue_count, 9'd0);
        check("drain_queueing", queueing, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
